// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline constants for the MIPS 5-stage front end.
package if_fetch_stage_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage_if_id_latch.sv
// IF/ID pipeline latch: instruction, next PC and valid flag.
// Priority per edge: rst > flush > stall > load.
module if_id_latch
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    npc_d,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    npc,
    output logic               valid
);

    // Capture the fetched instruction unless flushed or held.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= instr_d;
            npc   <= npc_d;
            valid <= 1'b1;
        end
    end

endmodule : if_id_latch

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID latch.
// Optional saturating performance counters are built when IF_PERF_CNT_EN
// is defined; otherwise fetch_count/redirect_count are tied to zero.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter int unsigned     PC_INCR  = 1,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    inst_addr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_npc,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   redirect_count
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_next;

    // Sequential PC wraps modulo 2^PC_W.
    assign pc_seq    = pc_q + PC_W'(PC_INCR);
    assign inst_addr = pc_q;

    // Next-PC select: redirect overrides stall, stall holds.
    always_comb begin
        pc_next = pc_seq;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    if_id_latch #(
        .PC_W (PC_W)
    ) u_if_id_latch (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (redirect),
        .instr_d (instr_in),
        .npc_d   (pc_seq),
        .instr   (if_id_instr),
        .npc     (if_id_npc),
        .valid   (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_count_q;
    logic [CNT_W-1:0] redirect_count_q;

    // Saturating counters: valid latch writes and redirects taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            if (!redirect && !stall && (fetch_count_q != '1)) begin
                fetch_count_q <= fetch_count_q + CNT_W'(1);
            end
            if (redirect && (redirect_count_q != '1)) begin
                redirect_count_q <= redirect_count_q + CNT_W'(1);
            end
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`else
    assign fetch_count    = '0;
    assign redirect_count = '0;
`endif

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a behavioural reference model.
module tb_if_fetch_stage;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [31:0]      instr_in;
    logic [PC_W-1:0]  inst_addr;
    logic [31:0]      if_id_instr;
    logic [PC_W-1:0]  if_id_npc;
    logic             if_id_valid;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] redirect_count;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;
    int          m_fc;
    int          m_rc;

    if_fetch_stage #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_in       (instr_in),
        .inst_addr      (inst_addr),
        .if_id_instr    (if_id_instr),
        .if_id_npc      (if_id_npc),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'd100;
    endfunction

    assign instr_in = mem(inst_addr);

    function automatic int exp_cnt(input int c);
        return PERF ? c : 0;
    endfunction

    // Drive one cycle of inputs, advance the model, settle at the negedge.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] tgt);
        rst = r; stall = s; redirect = d; redirect_pc = tgt;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            m_fc = 0; m_rc = 0;
        end else if (d) begin
            m_pc = tgt; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            if (m_rc < CMAX) m_rc++;
        end else if (!s) begin
            m_instr = mem(m_pc); m_npc = m_pc + 32'd1; m_valid = 1'b1;
            m_pc = m_pc + 32'd1;
            if (m_fc < CMAX) m_fc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h55);
        vectors++; if (inst_addr !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h expected %h", inst_addr, 32'h0); end
        vectors++; if (if_id_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h expected %h", if_id_instr, 32'h0); end
        vectors++; if (if_id_npc !== 32'h0) begin miscompares++; $display("FAIL reset_npc got %h expected %h", if_id_npc, 32'h0); end
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b expected 0", if_id_valid); end
        vectors++; if (fetch_count !== '0 || redirect_count !== '0) begin
            miscompares++; $display("FAIL reset_counts got %0d/%0d expected 0/0", fetch_count, redirect_count);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            vectors++; if (inst_addr !== 32'(i)) begin miscompares++; $display("FAIL run_pc[%0d] got %h expected %h", i, inst_addr, 32'(i)); end
            vectors++; if (if_id_instr !== 32'(99 + i) || if_id_npc !== 32'(i) || if_id_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL run_latch[%0d] got %h/%h/%b expected %h/%h/1", i, if_id_instr, if_id_npc, if_id_valid, 32'(99 + i), 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            vectors++; if (inst_addr !== 32'd4 || if_id_instr !== 32'd103 || if_id_npc !== 32'd4 || if_id_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got pc %h instr %h npc %h v %b expected 4/103/4/1", i, inst_addr, if_id_instr, if_id_npc, if_id_valid);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (inst_addr !== 32'd5 || if_id_instr !== 32'd104 || if_id_npc !== 32'd5) begin
            miscompares++; $display("FAIL stall_resume got %h/%h/%h expected 5/104/5", inst_addr, if_id_instr, if_id_npc);
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b0, 1'b1, 32'd40);
        vectors++; if (inst_addr !== 32'd40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_npc !== 32'h0) begin
            miscompares++; $display("FAIL redirect_bubble got pc %h v %b instr %h npc %h expected 40/0/0/0", inst_addr, if_id_valid, if_id_instr, if_id_npc);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (if_id_instr !== 32'd140 || if_id_npc !== 32'd41 || if_id_valid !== 1'b1) begin
            miscompares++; $display("FAIL redirect_target got %h/%h/%b expected 140/41/1", if_id_instr, if_id_npc, if_id_valid);
        end
    endtask

    task automatic test_redirect_stall();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        vectors++; if (inst_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            miscompares++; $display("FAIL redir_stall got pc %h v %b instr %h expected 200/0/0", inst_addr, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (inst_addr !== 32'h0 || if_id_npc !== 32'h0 || if_id_instr !== 32'd99 || if_id_valid !== 1'b1) begin
            miscompares++; $display("FAIL wrap got pc %h npc %h instr %h v %b expected 0/0/63/1", inst_addr, if_id_npc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1, 32'd6);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        vectors++; if (inst_addr !== 32'd7 || if_id_valid !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset got pc %h v %b expected 7/1", inst_addr, if_id_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        vectors++; if (inst_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== '0 || redirect_count !== '0) begin
            miscompares++; $display("FAIL mid_reset got pc %h v %b instr %h cnt %0d/%0d expected 0/0/0/0/0",
                                    inst_addr, if_id_valid, if_id_instr, fetch_count, redirect_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
        vectors++; if (fetch_count !== CNT_W'(exp_cnt(15))) begin
            miscompares++; $display("FAIL fetch_sat got %0d expected %0d", fetch_count, exp_cnt(15));
        end
        vectors++; if (redirect_count !== CNT_W'(exp_cnt(15))) begin
            miscompares++; $display("FAIL redirect_sat got %0d expected %0d", redirect_count, exp_cnt(15));
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), tgt);
            vectors++;
            if (inst_addr !== m_pc || if_id_instr !== m_instr || if_id_npc !== m_npc || if_id_valid !== m_valid ||
                fetch_count !== CNT_W'(exp_cnt(m_fc)) || redirect_count !== CNT_W'(exp_cnt(m_rc))) begin
                miscompares++;
                $display("FAIL random[%0d] got pc %h instr %h npc %h v %b fc %0d rc %0d expected %h %h %h %b %0d %0d",
                         i, inst_addr, if_id_instr, if_id_npc, if_id_valid, fetch_count, redirect_count,
                         m_pc, m_instr, m_npc, m_valid, exp_cnt(m_fc), exp_cnt(m_rc));
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_pc = '0; m_instr = '0; m_npc = '0; m_valid = 1'b0; m_fc = 0; m_rc = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_if_fetch_stage
